// File: rtl/xbar_slave_arbiter.sv
// xbar_slave_arbiter: shares one slave port among NUM_MASTERS request channels.
// Round-robin grant, command/address/data latched for the whole transaction,
// ack/rdata routed back to the owner only, optional ack timeout.
module xbar_slave_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*AWIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DWIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS-1:0]        m_err,
  output logic [DWIDTH-1:0]             m_rdata,
  output logic                          s_req,
  output logic                          s_cmd,
  output logic [AWIDTH-1:0]             s_addr,
  output logic [DWIDTH-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DWIDTH-1:0]             s_rdata,
  output logic [NUM_MASTERS-1:0]        grant
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]          TMAX   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0]          LAST0  = IW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_N  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REL} state_t;

  state_t                   r_state, w_nxt_state;
  logic [IW-1:0]            r_last,  w_nxt_last;
  logic [IW-1:0]            r_gidx,  w_nxt_gidx;
  logic [NUM_MASTERS-1:0]   r_grant, w_nxt_grant;
  logic                     r_s_req, w_nxt_s_req;
  logic                     r_s_cmd, w_nxt_s_cmd;
  logic [AWIDTH-1:0]        r_s_addr, w_nxt_s_addr;
  logic [DWIDTH-1:0]        r_s_wdata, w_nxt_s_wdata;
  logic [NUM_MASTERS-1:0]   r_m_ack, w_nxt_m_ack;
  logic [NUM_MASTERS-1:0]   r_m_err, w_nxt_m_err;
  logic [DWIDTH-1:0]        r_m_rdata, w_nxt_m_rdata;
  logic [CW-1:0]            r_cnt, w_nxt_cnt;

  logic                     w_any;
  logic [IW-1:0]            w_pick;

  // Round-robin scan: first requester after the last owner, with wrap.
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_pick = '0;
    idx    = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!w_any && m_req[idx]) begin
        w_any  = 1'b1;
        w_pick = IW'(idx);
      end
    end
  end

  // Next-state and next-output logic; pulses (ack/err/rdata) default to 0.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_last    = r_last;
    w_nxt_gidx    = r_gidx;
    w_nxt_grant   = r_grant;
    w_nxt_s_req   = r_s_req;
    w_nxt_s_cmd   = r_s_cmd;
    w_nxt_s_addr  = r_s_addr;
    w_nxt_s_wdata = r_s_wdata;
    w_nxt_m_ack   = '0;
    w_nxt_m_err   = '0;
    w_nxt_m_rdata = '0;
    w_nxt_cnt     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_nxt_state   = S_BUSY;
          w_nxt_gidx    = w_pick;
          w_nxt_grant   = ONE_N << w_pick;
          w_nxt_s_req   = 1'b1;
          w_nxt_s_cmd   = m_cmd[w_pick];
          w_nxt_s_addr  = m_addr[w_pick*AWIDTH +: AWIDTH];
          w_nxt_s_wdata = m_wdata[w_pick*DWIDTH +: DWIDTH];
          w_nxt_cnt     = '0;
        end
      end
      S_BUSY: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (s_ack || (TIMEOUT > 0 && r_cnt == TMAX)) begin
          w_nxt_state   = S_REL;
          w_nxt_s_req   = 1'b0;
          w_nxt_s_cmd   = 1'b0;
          w_nxt_s_addr  = '0;
          w_nxt_s_wdata = '0;
          w_nxt_m_ack   = r_grant;
          w_nxt_m_err   = s_ack ? '0 : r_grant;
          w_nxt_m_rdata = (s_ack && !r_s_cmd) ? s_rdata : '0;
        end else if (TIMEOUT > 0) begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_REL: begin
        // Owner keeps the grant until it drops its request.
        if (!m_req[r_gidx]) begin
          w_nxt_state = S_IDLE;
          w_nxt_grant = '0;
          w_nxt_last  = r_gidx;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction without ack.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= S_IDLE;
      r_last    <= LAST0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_s_req   <= 1'b0;
      r_s_cmd   <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_m_ack   <= '0;
      r_m_err   <= '0;
      r_m_rdata <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_last    <= w_nxt_last;
      r_gidx    <= w_nxt_gidx;
      r_grant   <= w_nxt_grant;
      r_s_req   <= w_nxt_s_req;
      r_s_cmd   <= w_nxt_s_cmd;
      r_s_addr  <= w_nxt_s_addr;
      r_s_wdata <= w_nxt_s_wdata;
      r_m_ack   <= w_nxt_m_ack;
      r_m_err   <= w_nxt_m_err;
      r_m_rdata <= w_nxt_m_rdata;
      r_cnt     <= w_nxt_cnt;
    end
  end

  assign m_ack   = r_m_ack;
  assign m_err   = r_m_err;
  assign m_rdata = r_m_rdata;
  assign s_req   = r_s_req;
  assign s_cmd   = r_s_cmd;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign grant   = r_grant;

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter (2 masters, TIMEOUT=8).
module tb_xbar_slave_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    m_req, m_cmd, m_ack, m_err, grant;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic            s_req, s_cmd, s_ack;

  int n_tests = 0;
  int n_fail  = 0;

  xbar_slave_arbiter #(.NUM_MASTERS(N), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(8)) dut (
    .aclk(aclk), .areset(areset),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .grant(grant)
  );

  always #5 aclk = ~aclk;

  // Advance one edge; drive and sample 1 time unit after it.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    tick(); tick();
    areset = 1'b0;
    n_tests++;
    if ({grant, s_req, s_cmd, m_ack, m_err} !== '0 || s_addr !== '0 || s_wdata !== '0 || m_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset: grant=%b s_req=%b m_ack=%b m_err=%b s_addr=%h, required all zero", grant, s_req, m_ack, m_err, s_addr);
    end
  endtask

  task automatic test_write();
    m_req = 2'b01; m_cmd = 2'b01;
    m_addr[0 +: AW] = 32'h8000_0010; m_wdata[0 +: DW] = 32'hDEAD_BEEF;
    tick();
    n_tests++;
    if (s_req !== 1'b1 || s_cmd !== 1'b1 || s_addr !== 32'h8000_0010 || s_wdata !== 32'hDEAD_BEEF || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL write_issue: s_req=%b s_cmd=%b s_addr=%h s_wdata=%h grant=%b, required 1 1 80000010 deadbeef 01", s_req, s_cmd, s_addr, s_wdata, grant);
    end
    // master 0 changes its inputs; the slave side must stay latched
    m_addr[0 +: AW] = 32'h0; m_wdata[0 +: DW] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (m_ack !== 2'b00 || s_req !== 1'b1 || s_addr !== 32'h8000_0010) begin
        n_fail++;
        $display("FAIL write_wait%0d: m_ack=%b s_req=%b s_addr=%h, required 00 1 80000010", i, m_ack, s_req, s_addr);
      end
    end
    s_ack = 1'b1; s_rdata = 32'hAAAA_5555;
    tick();
    n_tests++;
    if (m_ack !== 2'b01 || m_err !== 2'b00 || s_req !== 1'b0 || s_addr !== '0 || m_rdata !== '0) begin
      n_fail++;
      $display("FAIL write_ack: m_ack=%b m_err=%b s_req=%b s_addr=%h m_rdata=%h, required 01 00 0 0 0", m_ack, m_err, s_req, s_addr, m_rdata);
    end
    s_ack = 1'b0; m_req = 2'b00;
    tick();
    n_tests++;
    if (m_ack !== 2'b00 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL write_release: m_ack=%b grant=%b, required 00 00", m_ack, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    pulse_reset();
    m_cmd = 2'b00;
    m_addr = {32'h0000_0200, 32'h0000_0100};
    m_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_tests++;
      if (grant !== exp || s_req !== 1'b1 || s_addr !== ((t % 2 == 0) ? 32'h100 : 32'h200)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: grant=%b s_req=%b s_addr=%h, required %b 1", t, grant, s_req, s_addr, exp);
      end
      s_ack = 1'b1; s_rdata = 32'h1000 + t;
      tick();
      n_tests++;
      if (m_ack !== exp || m_rdata !== 32'h1000 + t) begin
        n_fail++;
        $display("FAIL rr_ack%0d: m_ack=%b m_rdata=%h, required %b %h", t, m_ack, m_rdata, exp, 32'h1000 + t);
      end
      s_ack = 1'b0; m_req = 2'b11 & ~exp;
      tick();
      n_tests++;
      if (grant !== 2'b00 || m_ack !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_idle%0d: grant=%b m_ack=%b, required 00 00", t, grant, m_ack);
      end
      m_req = 2'b11;
    end
    m_req = 2'b00;
    tick();
  endtask

  task automatic test_read_m1();
    m_req = 2'b10; m_cmd = 2'b00; m_addr[AW +: AW] = 32'h44;
    tick();
    n_tests++;
    if (grant !== 2'b10 || s_cmd !== 1'b0 || s_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL read_issue: grant=%b s_cmd=%b s_addr=%h, required 10 0 44", grant, s_cmd, s_addr);
    end
    s_ack = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    n_tests++;
    if (m_ack !== 2'b10 || m_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL read_ack: m_ack=%b m_rdata=%h, required 10 12345678", m_ack, m_rdata);
    end
    s_ack = 1'b0; s_rdata = 32'hFFFF_FFFF; m_req = 2'b00;
    tick();
    n_tests++;
    if (m_ack !== 2'b00 || m_rdata !== '0) begin
      n_fail++;
      $display("FAIL read_after: m_ack=%b m_rdata=%h, required 00 0", m_ack, m_rdata);
    end
  endtask

  task automatic test_timeout();
    // last owner is master 1, so master 0 wins the scan
    m_req = 2'b11; m_cmd = 2'b00; s_rdata = 32'h5A5A_5A5A;
    tick();
    n_tests++;
    if (grant !== 2'b01 || s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL to_issue: grant=%b s_req=%b, required 01 1", grant, s_req);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      n_tests++;
      if (m_ack !== 2'b00 || m_err !== 2'b00 || s_req !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait%0d: m_ack=%b m_err=%b s_req=%b, required 00 00 1", i, m_ack, m_err, s_req);
      end
    end
    tick();
    n_tests++;
    if (m_ack !== 2'b01 || m_err !== 2'b01 || s_req !== 1'b0 || m_rdata !== '0) begin
      n_fail++;
      $display("FAIL to_expire: m_ack=%b m_err=%b s_req=%b m_rdata=%h, required 01 01 0 0", m_ack, m_err, s_req, m_rdata);
    end
    m_req = 2'b10;
    tick(); tick();
    n_tests++;
    if (grant !== 2'b10 || s_req !== 1'b1 || m_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL to_next: grant=%b s_req=%b m_ack=%b, required 10 1 00", grant, s_req, m_ack);
    end
    // ack lands on the expiry cycle: completion, no error
    for (int i = 1; i < 8; i++) tick();
    s_ack = 1'b1;
    tick();
    n_tests++;
    if (m_ack !== 2'b10 || m_err !== 2'b00 || m_rdata !== 32'h5A5A_5A5A) begin
      n_fail++;
      $display("FAIL to_ack_wins: m_ack=%b m_err=%b m_rdata=%h, required 10 00 5a5a5a5a", m_ack, m_err, m_rdata);
    end
    s_ack = 1'b0; m_req = 2'b00;
    tick();
  endtask

  task automatic test_reset_busy();
    // master 0 transaction completes, so the pointer moves to master 0
    m_req = 2'b01; m_cmd = 2'b01;
    tick();
    s_ack = 1'b1; tick(); s_ack = 1'b0; m_req = 2'b00; tick();
    m_req = 2'b10; m_cmd = 2'b10; m_addr[AW +: AW] = 32'hCAFE_0000; m_wdata[DW +: DW] = 32'h1111_2222;
    tick();
    n_tests++;
    if (grant !== 2'b10 || s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_busy: grant=%b s_req=%b, required 10 1", grant, s_req);
    end
    areset = 1'b1;
    tick();
    areset = 1'b0; m_req = 2'b11;
    n_tests++;
    if ({grant, s_req, s_cmd, m_ack, m_err} !== '0 || s_addr !== '0 || s_wdata !== '0) begin
      n_fail++;
      $display("FAIL rb_cleared: grant=%b s_req=%b m_ack=%b s_addr=%h s_wdata=%h, required all zero", grant, s_req, m_ack, s_addr, s_wdata);
    end
    tick();
    n_tests++;
    if (grant !== 2'b01 || m_ack !== 2'b00) begin
      n_fail++;
      $display("FAIL rb_regrant: grant=%b m_ack=%b, required 01 00", grant, m_ack);
    end
    s_ack = 1'b1; tick(); s_ack = 1'b0; m_req = 2'b00; tick();
  endtask

  task automatic test_hold();
    pulse_reset();
    m_req = 2'b11; m_cmd = 2'b00;
    tick();
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    n_tests++;
    if (m_ack !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_ack: m_ack=%b, required 01", m_ack);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (grant !== 2'b01 || s_req !== 1'b0 || m_ack !== 2'b00 || m_err !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_wait%0d: grant=%b s_req=%b m_ack=%b m_err=%b, required 01 0 00 00", i, grant, s_req, m_ack, m_err);
      end
    end
    m_req = 2'b10;
    tick();
    n_tests++;
    if (grant !== 2'b00 || s_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop: grant=%b s_req=%b, required 00 0", grant, s_req);
    end
    tick();
    n_tests++;
    if (grant !== 2'b10 || s_req !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_next: grant=%b s_req=%b, required 10 1", grant, s_req);
    end
    s_ack = 1'b1; tick(); s_ack = 1'b0; m_req = 2'b00; tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read_m1();
    test_timeout();
    test_reset_busy();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
